// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: two-requester round-robin front end for a shared
// fixed-latency floating-point add/sub datapath.
// Grants are combinational, operands are registered one cycle before issue,
// and a tag shift register routes each result back to its requester
// Latency+2 cycles after the request transfer.
// Optional feature: define FPU_ARB_STATS_EN to add the 16-bit saturating
// per-requester grant counters GNT0_CNT / GNT1_CNT.
module fpu_addsub_arbiter #(
  parameter int DataSize = 32,
  parameter int Latency  = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ0_VALID,
  input  logic [DataSize-1:0] REQ0_A,
  input  logic [DataSize-1:0] REQ0_B,
  input  logic                REQ0_OP,
  output logic                REQ0_READY,
  input  logic                REQ1_VALID,
  input  logic [DataSize-1:0] REQ1_A,
  input  logic [DataSize-1:0] REQ1_B,
  input  logic                REQ1_OP,
  output logic                REQ1_READY,
  output logic [DataSize-1:0] FPU_A,
  output logic [DataSize-1:0] FPU_B,
  output logic                FPU_OP,
  output logic                FPU_EN,
  input  logic [DataSize-1:0] FPU_RESULT,
  output logic                RSP0_VALID,
  output logic                RSP1_VALID,
  output logic [DataSize-1:0] RSP_DATA,
`ifdef FPU_ARB_STATS_EN
  output logic [15:0]         GNT0_CNT,
  output logic [15:0]         GNT1_CNT,
`endif
  output logic                BUSY
);

  // Id of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic                last_gnt_reg;
  logic                gnt0;
  logic                gnt1;

  logic [DataSize-1:0] a_reg;
  logic [DataSize-1:0] b_reg;
  logic                op_reg;
  logic                en_reg;
  logic                id_reg;

  // Bit k of the tag pipeline describes the operation issued k+1 cycles ago.
  logic [Latency-1:0]  tag_valid_reg;
  logic [Latency-1:0]  tag_valid_next;
  logic [Latency-1:0]  tag_id_reg;
  logic [Latency-1:0]  tag_id_next;

  logic                rsp0_reg;
  logic                rsp1_reg;
  logic [DataSize-1:0] rsp_data_reg;

  // Round-robin grant: a lone requester always wins, a tie goes to the one
  // not granted last; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (REQ0_VALID && (!REQ1_VALID || last_gnt_reg)) begin
        gnt0 = 1'b1;
      end else if (REQ1_VALID) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign REQ0_READY = gnt0;
  assign REQ1_READY = gnt1;

  // Priority pointer moves only when a transfer actually happens.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt_reg <= 1'b1;
    end else if (gnt0) begin
      last_gnt_reg <= 1'b0;
    end else if (gnt1) begin
      last_gnt_reg <= 1'b1;
    end
  end

  // Issue stage: capture the granted operands; hold them when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_reg <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      id_reg <= 1'b0;
    end else begin
      en_reg <= gnt0 | gnt1;
      if (gnt0) begin
        a_reg  <= REQ0_A;
        b_reg  <= REQ0_B;
        op_reg <= REQ0_OP;
        id_reg <= 1'b0;
      end else if (gnt1) begin
        a_reg  <= REQ1_A;
        b_reg  <= REQ1_B;
        op_reg <= REQ1_OP;
        id_reg <= 1'b1;
      end
    end
  end

  assign FPU_A  = a_reg;
  assign FPU_B  = b_reg;
  assign FPU_OP = op_reg;
  assign FPU_EN = en_reg;

  // Tag pipeline wiring: stage 0 takes the issue strobe, later stages shift.
  genvar gi;
  generate
    for (gi = 0; gi < Latency; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = en_reg;
        assign tag_id_next[gi]    = id_reg;
      end else begin : g_shift
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_id_next[gi]    = tag_id_reg[gi-1];
      end
    end
  endgenerate

  // Tag pipeline register; reset drops every in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_id_reg    <= tag_id_next;
    end
  end

  // Response stage: sample the datapath when the oldest tag is valid and
  // pulse the owner's valid for one cycle; data holds otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp0_reg     <= 1'b0;
      rsp1_reg     <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      rsp0_reg <= tag_valid_reg[Latency-1] & ~tag_id_reg[Latency-1];
      rsp1_reg <= tag_valid_reg[Latency-1] &  tag_id_reg[Latency-1];
      if (tag_valid_reg[Latency-1]) begin
        rsp_data_reg <= FPU_RESULT;
      end
    end
  end

  assign RSP0_VALID = rsp0_reg;
  assign RSP1_VALID = rsp1_reg;
  assign RSP_DATA   = rsp_data_reg;
  assign BUSY       = en_reg | (|tag_valid_reg);

`ifdef FPU_ARB_STATS_EN
  logic [15:0] gnt0_cnt_reg;
  logic [15:0] gnt1_cnt_reg;

  // Saturating per-requester transfer counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt0_cnt_reg <= '0;
      gnt1_cnt_reg <= '0;
    end else begin
      if (gnt0 && (gnt0_cnt_reg != 16'hFFFF)) begin
        gnt0_cnt_reg <= gnt0_cnt_reg + 16'd1;
      end
      if (gnt1 && (gnt1_cnt_reg != 16'hFFFF)) begin
        gnt1_cnt_reg <= gnt1_cnt_reg + 16'd1;
      end
    end
  end

  assign GNT0_CNT = gnt0_cnt_reg;
  assign GNT1_CNT = gnt1_cnt_reg;
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter: cycle-stepped bench for fpu_addsub_arbiter.
// A transaction-level model predicts grants, issue contents, response
// timing/data and BUSY from the arbitration rules; a datapath stub answers
// FPU_EN with a result Latency cycles later and garbage otherwise.
// Build with FPU_ARB_STATS_EN defined to also exercise the grant counters.
module tb_fpu_addsub_arbiter;

  localparam int DW = 32;
  localparam int L  = 3;
  localparam int N  = 32;   // ring size for per-cycle expectation slots

  logic          CLK;
  logic          RST;
  logic          REQ0_VALID, REQ1_VALID;
  logic [DW-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic          REQ0_OP, REQ1_OP;
  logic          REQ0_READY, REQ1_READY;
  logic [DW-1:0] FPU_A, FPU_B;
  logic          FPU_OP, FPU_EN;
  logic [DW-1:0] FPU_RESULT;
  logic          RSP0_VALID, RSP1_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          BUSY;
`ifdef FPU_ARB_STATS_EN
  logic [15:0]   GNT0_CNT, GNT1_CNT;
`endif

  fpu_addsub_arbiter #(.DataSize(DW), .Latency(L)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP),
    .REQ1_READY(REQ1_READY),
    .FPU_A(FPU_A), .FPU_B(FPU_B), .FPU_OP(FPU_OP), .FPU_EN(FPU_EN),
    .FPU_RESULT(FPU_RESULT),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID), .RSP_DATA(RSP_DATA),
`ifdef FPU_ARB_STATS_EN
    .GNT0_CNT(GNT0_CNT), .GNT1_CNT(GNT1_CNT),
`endif
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int floor_c = 0;       // first cycle whose transfers survive the last reset
  bit last_g = 1'b1;     // model: id granted last
  bit verbose = 1'b0;

  // Model expectations, indexed by absolute cycle modulo N.
  bit            ex_en [N];
  logic [DW-1:0] ex_a  [N];
  logic [DW-1:0] ex_b  [N];
  bit            ex_op [N];
  bit            ex_rv [N];
  bit            ex_rid[N];
  logic [DW-1:0] ex_rd [N];
  bit            xfer  [N];
  logic [DW-1:0] cur_a = '0, cur_b = '0, cur_rd = '0;
  bit            cur_op = 1'b0;

  // Datapath stub history (what the DUT issued each cycle).
  bit            st_en[N];
  logic [DW-1:0] st_a [N];
  logic [DW-1:0] st_b [N];
  bit            st_op[N];

  // Sampled outputs of the most recent step.
  bit s_r0, s_r1, s_en, s_rsp0, s_rsp1, s_busy;
  logic [DW-1:0] s_a, s_rd;

`ifdef FPU_ARB_STATS_EN
  int m_cnt0 = 0, m_cnt1 = 0;
`endif

  function automatic logic [DW-1:0] fres(logic [DW-1:0] a, logic [DW-1:0] b, bit op);
    return op ? (a - b) : (a + b);
  endfunction

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model with this cycle's transfer (if any).
  task automatic step(input bit rst, input bit v0, input logic [DW-1:0] a0,
                      input logic [DW-1:0] b0, input bit op0, input bit v1,
                      input logic [DW-1:0] a1, input logic [DW-1:0] b1, input bit op1);
    bit e_r0, e_r1, e_busy, id;
    int i, j, p;
    @(posedge CLK);
    #1;
    RST = rst;
    REQ0_VALID = v0; REQ0_A = a0; REQ0_B = b0; REQ0_OP = op0;
    REQ1_VALID = v1; REQ1_A = a1; REQ1_B = b1; REQ1_OP = op1;
    p = (cyc - L + N) % N;
    if (cyc >= L && st_en[p]) FPU_RESULT = fres(st_a[p], st_b[p], st_op[p]);
    else FPU_RESULT = $urandom;
    #3;
    i = cyc % N;
    e_r0 = !rst && v0 && (!v1 || last_g);
    e_r1 = !rst && v1 && !e_r0;
    if (ex_en[i]) begin
      cur_a = ex_a[i]; cur_b = ex_b[i]; cur_op = ex_op[i];
    end
    if (ex_rv[i]) cur_rd = ex_rd[i];
    e_busy = 1'b0;
    for (int k = cyc - 1 - L; k < cyc; k++)
      if (k >= floor_c && k >= 0 && xfer[k % N]) e_busy = 1'b1;
    chk1("ready0", REQ0_READY, e_r0);
    chk1("ready1", REQ1_READY, e_r1);
    chk1("fpu_en", FPU_EN, ex_en[i]);
    chk32("fpu_a", FPU_A, cur_a);
    chk32("fpu_b", FPU_B, cur_b);
    chk1("fpu_op", FPU_OP, cur_op);
    chk1("rsp0_valid", RSP0_VALID, ex_rv[i] && !ex_rid[i]);
    chk1("rsp1_valid", RSP1_VALID, ex_rv[i] && ex_rid[i]);
    chk32("rsp_data", RSP_DATA, cur_rd);
    chk1("busy", BUSY, e_busy);
    s_r0 = REQ0_READY; s_r1 = REQ1_READY; s_en = FPU_EN; s_a = FPU_A;
    s_rsp0 = RSP0_VALID; s_rsp1 = RSP1_VALID; s_rd = RSP_DATA; s_busy = BUSY;
    if (verbose && (RSP0_VALID || RSP1_VALID))
      $display("cyc=%0d rsp id=%0d data=%h", cyc, RSP1_VALID, RSP_DATA);
    st_en[i] = FPU_EN; st_a[i] = FPU_A; st_b[i] = FPU_B; st_op[i] = FPU_OP;
    ex_en[i] = 1'b0; ex_rv[i] = 1'b0;
    xfer[i] = 1'b0;
    if (e_r0 || e_r1) begin
      id = e_r1;
      xfer[i] = 1'b1;
      last_g = id;
      j = (cyc + 1) % N;
      ex_en[j] = 1'b1;
      ex_a[j] = id ? a1 : a0; ex_b[j] = id ? b1 : b0; ex_op[j] = id ? op1 : op0;
      j = (cyc + L + 2) % N;
      ex_rv[j] = 1'b1; ex_rid[j] = id;
      ex_rd[j] = id ? fres(a1, b1, op1) : fres(a0, b0, op0);
    end
`ifdef FPU_ARB_STATS_EN
    if (e_r0 && m_cnt0 < 65535) m_cnt0++;
    if (e_r1 && m_cnt1 < 65535) m_cnt1++;
    if (rst) begin m_cnt0 = 0; m_cnt1 = 0; end
`endif
    if (rst) begin
      for (int k = cyc + 1; k <= cyc + L + 3; k++) begin
        ex_en[k % N] = 1'b0; ex_rv[k % N] = 1'b0;
      end
      last_g = 1'b1;
      floor_c = cyc + 1;
      cur_a = '0; cur_b = '0; cur_op = 1'b0; cur_rd = '0;
    end
    cyc++;
  endtask

  task automatic idle(input bit rst);
    step(rst, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  typedef struct {
    bit v0;
    bit v1;
    bit exp_r0;
    bit exp_r1;
  } vec_t;

  vec_t vecs[8];
  int lat;
  bit found;
  int rsp_ids[$];
  int first_c, last_c, nrsp;

  initial begin
    // Grant table after reset: tie, tie, lone 1, lone 1, tie, none, lone 0, tie.
    vecs[0] = '{1, 1, 1, 0};
    vecs[1] = '{1, 1, 0, 1};
    vecs[2] = '{0, 1, 0, 1};
    vecs[3] = '{0, 1, 0, 1};
    vecs[4] = '{1, 1, 1, 0};
    vecs[5] = '{0, 0, 0, 0};
    vecs[6] = '{1, 0, 1, 0};
    vecs[7] = '{1, 1, 0, 1};

    RST = 1'b1;
    REQ0_VALID = 0; REQ1_VALID = 0; REQ0_OP = 0; REQ1_OP = 0;
    REQ0_A = '0; REQ0_B = '0; REQ1_A = '0; REQ1_B = '0; FPU_RESULT = '0;
    repeat (3) @(posedge CLK);
    idle(1'b1);            // reset cycle: model aligned, reset state checked
    idle(1'b0);

    // Single REQ0 add, response Latency+2 cycles after the transfer.
    step(1'b0, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, '0, '0, 1'b0);
    chk1("single_ready0", s_r0, 1'b1);
    found = 1'b0; lat = -1;
    for (int n = 1; n <= 10; n++) begin
      idle(1'b0);
      if (n == 1) begin
        chk1("single_fpu_en", s_en, 1'b1);
        chk32("single_fpu_a", s_a, 32'h3F800000);
      end
      if (s_rsp0 && !found) begin
        found = 1'b1; lat = n;
        chk32("single_rsp_data", s_rd, 32'h7F800000);
      end
    end
    chk32("single_latency", 32'(lat), 32'(L + 2));
    $display("single request: latency=%0d data=%h", lat, s_rd);

    // Table of grant patterns.
    idle(1'b1);
    for (int v = 0; v < 8; v++) begin
      step(1'b0, vecs[v].v0, $urandom, $urandom, 1'($urandom), vecs[v].v1, $urandom, $urandom, 1'($urandom));
      chk1("table_r0", s_r0, vecs[v].exp_r0);
      chk1("table_r1", s_r1, vecs[v].exp_r1);
      $display("vector %0d v0=%0d v1=%0d grant r0=%0d r1=%0d", v, vecs[v].v0, vecs[v].v1, s_r0, s_r1);
    end
    repeat (L + 3) idle(1'b0);

    // Both requesters held for 6 cycles: alternating grants and responses.
    idle(1'b1);
    rsp_ids.delete(); first_c = -1; last_c = -1;
    for (int n = 0; n < 6 + L + 4; n++) begin
      if (n < 6) begin
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1, $urandom, $urandom, 1'b1);
        chk1("alt_grant1", s_r1, 1'(n % 2));
        chk1("alt_grant0", s_r0, 1'((n + 1) % 2));
      end else begin
        idle(1'b0);
      end
      if (s_rsp0 || s_rsp1) begin
        rsp_ids.push_back(int'(s_rsp1));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    chk32("alt_rsp_count", 32'(rsp_ids.size()), 32'd6);
    for (int n = 0; n < rsp_ids.size(); n++) chk32("alt_rsp_id", 32'(rsp_ids[n]), 32'(n % 2));
    chk32("alt_rsp_span", 32'(last_c - first_c), 32'd5);
    $display("alternating: %0d responses over %0d cycles", rsp_ids.size(), last_c - first_c + 1);

    // Only REQ1 for 4 cycles.
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, $urandom, $urandom, 1'($urandom));
      chk1("only1_r1", s_r1, 1'b1);
      chk1("only1_r0", s_r0, 1'b0);
    end
    repeat (L + 3) idle(1'b0);
    $display("requester 1 alone: 4 grants");

    // Reset while three issues are in flight.
    for (int n = 0; n < 3; n++)
      step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    nrsp = 0;
    for (int n = 0; n < L + 5; n++) begin
      idle(1'b0);
      if (n == 0) chk1("flush_busy", s_busy, 1'b0);
      if (s_rsp0 || s_rsp1) nrsp++;
    end
    chk32("flush_rsp_count", 32'(nrsp), 32'd0);
    step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1, $urandom, $urandom, 1'b0);
    chk1("flush_next_grant0", s_r0, 1'b1);
    repeat (L + 3) idle(1'b0);
    $display("reset flush: %0d stray responses", nrsp);

    // Randomized traffic with occasional resets.
    verbose = 1'b1;
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom, $urandom, 1'($urandom));
    end
    verbose = 1'b0;
    repeat (L + 3) idle(1'b0);

`ifdef FPU_ARB_STATS_EN
    idle(1'b1);
    for (int n = 0; n < 70000; n++) begin
      step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, '0, '0, 1'b0);
      if (n == 99) chk32("stats_cnt0_100", 32'(GNT0_CNT), 32'(m_cnt0 - 1));
    end
    idle(1'b0);
    chk32("stats_cnt0_sat", 32'(GNT0_CNT), 32'h0000FFFF);
    chk32("stats_cnt1", 32'(GNT1_CNT), 32'(m_cnt1));
    $display("stats: GNT0_CNT=%h GNT1_CNT=%h", GNT0_CNT, GNT1_CNT);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
